usb_rx_byte_assembler: RTL and testbench

- Receive-path stage directly downstream of the bit unstuffer.
- Consumes the unstuffed serial bitstream (bit + valid strobe) and an EOP strobe from the line-state decoder.
- Hunts for the SYNC pattern, then assembles LSB-first bytes. Flags the first byte of each packet (PID) and reports per-packet status at EOP.
- Output feeds the packet decoder / CRC checker.

---
 rtl/usb_rx_pkg.sv | 20 ++
 rtl/usb_rx_byte_assembler_sync_hunter.sv | 45 ++++
 rtl/usb_rx_byte_assembler.sv | 156 +++++++++++++++
 tb/tb_usb_rx_byte_assembler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// The PID complement check is used only when USB_RX_PID_CHECK_EN is defined.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PID,
        DATA,
        DISCARD
    } rx_state_t;

    localparam int SYNC_ZEROS_MAX    = 7;
    localparam int MAX_BYTES_DEFAULT = 1027;

    // A PID is well formed when its upper nibble is the bitwise inverse of the lower nibble.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_byte_assembler_sync_hunter.sv
// SYNC detector: counts a run of zeros (saturating) and strobes sync_found
// on the terminating one bit when the run is long enough.
module usb_sync_hunter
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5
) (
    input  logic clk,
    input  logic nRST,
    input  logic en,
    input  logic in_bit,
    input  logic in_valid,
    output logic sync_found
);

    localparam logic [2:0] MIN_ZEROS = 3'(SYNC_MIN_ZEROS);
    localparam logic [2:0] SAT_ZEROS = 3'(SYNC_ZEROS_MAX);

    logic [2:0] zero_cnt_q;
    logic [2:0] zero_cnt_d;

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        sync_found = 1'b0;
        if (!en) begin
            zero_cnt_d = 3'd0;
        end else if (in_valid) begin
            if (in_bit) begin
                sync_found = (zero_cnt_q >= MIN_ZEROS);
                zero_cnt_d = 3'd0;
            end else if (zero_cnt_q != SAT_ZEROS) begin
                zero_cnt_d = zero_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            zero_cnt_q <= 3'd0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// Assembles unstuffed USB bits into LSB-first bytes after SYNC, flags the PID
// byte and reports packet status at EOP. Optional PID check: USB_RX_PID_CHECK_EN.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int MAX_BYTES      = MAX_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       eop,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       pid_err,
    output logic       align_err,
    output logic       len_err
);

    localparam int BCW = $clog2(MAX_BYTES + 1);
    localparam logic [BCW-1:0] MAX_B = BCW'(MAX_BYTES);

    rx_state_t      state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]     out_byte_q, out_byte_d;
    logic           out_valid_q, out_valid_d;
    logic           out_sop_q, out_sop_d;
    logic           out_eop_q, out_eop_d;
    logic           pid_err_q, pid_err_d;
    logic           align_err_q, align_err_d;
    logic           len_err_q, len_err_d;
    logic           pid_st_q, pid_st_d;
    logic           len_st_q, len_st_d;
    logic [7:0]     byte_next;
    logic           sync_found;

    // A bit that coincides with EOP is dropped, in the hunter as well.
    usb_sync_hunter #(
        .SYNC_MIN_ZEROS(SYNC_MIN_ZEROS)
    ) u_sync_hunter (
        .clk        (clk),
        .nRST       (nRST),
        .en         (state_q == HUNT),
        .in_bit     (in_bit),
        .in_valid   (in_valid & ~eop),
        .sync_found (sync_found)
    );

    assign byte_next = {in_bit, shift_q[7:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        out_byte_d  = out_byte_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        pid_err_d   = 1'b0;
        align_err_d = 1'b0;
        len_err_d   = 1'b0;
        pid_st_d    = pid_st_q;
        len_st_d    = len_st_q;
        case (state_q)
            HUNT: begin
                if (sync_found) begin
                    state_d    = PID;
                    shift_d    = 8'd0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    pid_st_d   = 1'b0;
                    len_st_d   = 1'b0;
                end
            end
            default: begin
                if (eop) begin
                    out_eop_d   = 1'b1;
                    pid_err_d   = pid_st_q;
                    len_err_d   = len_st_q;
                    align_err_d = (state_q != DISCARD) && (bit_cnt_q >= 3'd2);
                    state_d     = HUNT;
                    shift_d     = 8'd0;
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = '0;
                end else if (in_valid && state_q != DISCARD) begin
                    if (byte_cnt_q == MAX_B) begin
                        state_d  = DISCARD;
                        len_st_d = 1'b1;
                    end else begin
                        shift_d   = byte_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            out_byte_d  = byte_next;
                            out_valid_d = 1'b1;
                            out_sop_d   = (state_q == PID);
                            byte_cnt_d  = byte_cnt_q + BCW'(1);
                            state_d     = DATA;
`ifdef USB_RX_PID_CHECK_EN
                            if (state_q == PID) begin
                                pid_st_d = ~pid_ok(byte_next);
                            end
`endif
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= HUNT;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pid_err_q   <= 1'b0;
            align_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            pid_st_q    <= 1'b0;
            len_st_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            pid_err_q   <= pid_err_d;
            align_err_q <= align_err_d;
            len_err_q   <= len_err_d;
            pid_st_q    <= pid_st_d;
            len_st_q    <= len_st_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign pid_err   = pid_err_q;
    assign align_err = align_err_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Bench for usb_rx_byte_assembler: table of packets driven bit by bit, with a
// scoreboard of expected bytes / EOP status popped by a negedge monitor.
module tb_usb_rx_byte_assembler;

    localparam int SMZ  = 5;
    localparam int MAXB = 4;
`ifdef USB_RX_PID_CHECK_EN
    localparam bit PID_CHK = 1'b1;
`else
    localparam bit PID_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] out_byte;
    logic       out_valid, out_sop, out_eop, pid_err, align_err, len_err;

    usb_rx_byte_assembler #(
        .SYNC_MIN_ZEROS(SMZ),
        .MAX_BYTES     (MAXB)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .eop       (eop),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pid_err   (pid_err),
        .align_err (align_err),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          z;
        logic [47:0] b;
        int          n;
        int          extra;
        logic        coinc;
        logic        pid_bad;
        logic        exp_align;
        logic        exp_len;
    } vec_t;

    // {eop, valid, byte, sop, pid_err, align_err, len_err}
    typedef logic [13:0] ev_t;

    ev_t  sb[$];
    vec_t tbl[12];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(int z, logic [47:0] b, int n, int extra,
                                logic coinc, logic pid_bad, logic ea, logic el);
        vec_t v;
        v.z = z; v.b = b; v.n = n; v.extra = extra;
        v.coinc = coinc; v.pid_bad = pid_bad; v.exp_align = ea; v.exp_len = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    task automatic monitor();
        ev_t act, e;
        forever begin
            @(negedge clk);
            if (nRST && (out_valid || out_eop)) begin
                act = {out_eop, out_valid, out_eop ? 8'h00 : out_byte, out_sop,
                       pid_err, align_err, len_err};
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(act), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk(out_eop ? "sb_eop" : "sb_byte", 32'(act), 32'(e));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap();
        idle($urandom_range(0, 1));
    endtask

    task automatic send_bit(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] bv, input bit emit, input bit sop);
        if (emit) sb.push_back({1'b0, 1'b1, bv, sop, 3'b000});
        for (int k = 0; k < 8; k++) begin
            send_bit(bv[k]);
            if (k < 7) gap();
        end
        chk("byte_latency", 32'(out_valid), 32'(emit));
        if (emit) chk("byte_value", 32'(out_byte), 32'(bv));
    endtask

    task automatic run_vec(input vec_t v);
        bit         synced;
        logic [7:0] bv;
        synced = (v.z >= SMZ);
        repeat (v.z) begin
            send_bit(1'b0);
            gap();
        end
        send_bit(1'b1);
        gap();
        for (int i = 0; i < v.n; i++) begin
            bv = v.b[8*i +: 8];
            send_byte(bv, synced && (i < MAXB), i == 0);
            if (i < v.n - 1 || v.extra > 0) gap();
        end
        for (int k = 0; k < v.extra; k++) send_bit((k % 2) == 1);
        if (synced)
            sb.push_back({1'b1, 1'b0, 8'h00, 1'b0,
                          PID_CHK & v.pid_bad, v.exp_align, v.exp_len});
        eop = 1'b1;
        if (v.coinc) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
        end
        @(posedge clk);
        #1;
        eop      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        chk("eop_latency", 32'(out_eop), 32'(synced));
        idle(3);
    endtask

    function automatic logic [31:0] all_outs();
        return {20'h0, out_byte, out_valid, out_sop, out_eop, pid_err, align_err, len_err};
    endfunction

    initial begin
        tbl[0]  = mk(7, 48'h0000_00C8_1569, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(5, 48'h0000_0000_00A5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(4, 48'h0000_0000_0055, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(6, 48'h0000_0000_0061, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(5, 48'h0000_0000_00E1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(5, 48'h0000_0000_00E1, 1, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6]  = mk(5, 48'h0000_0000_00E1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(5, 48'h5544_3322_11C3, 6, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(5, 48'h0000_0302_01C3, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(5, 48'h0000_0302_01C3, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(7, 48'h0000_0000_00D2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(5, 48'h0000_0000_0000, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0);

        fork
            monitor();
        join_none

        idle(2);
        chk("reset_outputs", all_outs(), 32'h0);
        #2 nRST = 1'b1;
        idle(2);

        for (int t = 0; t < 12; t++) begin
            $display("vector %0d", t);
            run_vec(tbl[t]);
        end

        // Async reset in the middle of a data byte, after a PID has been emitted.
        repeat (7) send_bit(1'b0);
        send_bit(1'b1);
        send_byte(8'hD2, 1'b1, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 nRST = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'h0);
        idle(2);
        nRST = 1'b1;
        idle(1);
        chk("post_reset_outputs", all_outs(), 32'h0);
        run_vec(tbl[10]);

        idle(3);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
